// File: rtl/dpram_wr_ctrl.sv
// rtl/dpram_wr_ctrl.sv - write-side packet controller for dpram_aclk with commit/rollback pointers
// Define DPRAM_WR_DROP_ON_FULL_EN to drop packets on full instead of applying backpressure.
module dpram_wr_ctrl #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  wr_clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_sop,
   input  logic                  in_eop,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [DATA_WIDTH-1:0] din,
   output logic [ADDR_WIDTH:0]   wr_ptr_gray,
   output logic [CNT_WIDTH-1:0]  drop_cnt
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [PW-1:0] LAST_LEN = {1'b0, {ADDR_WIDTH{1'b1}}};
   localparam logic [PW-1:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_t;

   state_t                r_state;
   state_t                w_state_nx;
   logic [PW-1:0]         r_wptr, r_cptr, r_len, r_sync1, r_sync2, r_wr_ptr_gray;
   logic                  r_active, r_we;
   logic [ADDR_WIDTH-1:0] r_waddr;
   logic [DATA_WIDTH-1:0] r_din;
   logic [CNT_WIDTH-1:0]  r_drop_cnt;

   logic [PW-1:0]         w_rptr, w_used, w_free;
   logic [PW-1:0]         w_wptr_nx, w_cptr_nx, w_len_nx, w_base, w_wr_ptr;
   logic                  w_full, w_accept, w_wr, w_drop, w_start;

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   assign w_rptr   = gray2bin(r_sync2);
   assign w_used   = r_wptr - w_rptr;
   assign w_free   = DEPTH - w_used;
   assign w_full   = (w_free == '0);
   assign w_accept = in_valid & in_ready;

`ifdef DPRAM_WR_DROP_ON_FULL_EN
   assign in_ready = r_active;
`else
   assign in_ready = r_active & ((r_state == S_DROP) | ~w_full);
`endif

   always_comb begin
      w_state_nx = r_state;
      w_wptr_nx  = r_wptr;
      w_cptr_nx  = r_cptr;
      w_len_nx   = r_len;
      w_wr       = 1'b0;
      w_drop     = 1'b0;
      w_start    = 1'b0;
      w_base     = r_wptr;
      w_wr_ptr   = r_wptr;
      case (r_state)
         S_IDLE: begin
            if (w_accept && in_sop) begin
`ifdef DPRAM_WR_DROP_ON_FULL_EN
               if (w_full) begin
                  w_drop     = 1'b1;
                  w_state_nx = in_eop ? S_IDLE : S_DROP;
               end else begin
                  w_start = 1'b1;
               end
`else
               w_start = 1'b1;
`endif
            end
         end
         S_WRITE: begin
            if (w_accept) begin
               // A fresh sop abandons the open packet and restarts at the commit point
               if (in_sop) begin
                  w_drop  = 1'b1;
                  w_start = 1'b1;
                  w_base  = r_cptr;
               end
`ifdef DPRAM_WR_DROP_ON_FULL_EN
               else if (w_full) begin
                  w_drop     = 1'b1;
                  w_wptr_nx  = r_cptr;
                  w_state_nx = in_eop ? S_IDLE : S_DROP;
               end
`endif
               else begin
                  w_wr      = 1'b1;
                  w_wptr_nx = r_wptr + ONE;
                  if (in_eop) begin
                     w_cptr_nx  = r_wptr + ONE;
                     w_state_nx = S_IDLE;
                  end else if (r_len == LAST_LEN) begin
                     w_drop     = 1'b1;
                     w_wptr_nx  = r_cptr;
                     w_state_nx = S_DROP;
                  end else begin
                     w_len_nx = r_len + ONE;
                  end
               end
            end
         end
         S_DROP: begin
            if (w_accept && in_eop) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase

      if (w_start) begin
         w_wr      = 1'b1;
         w_wr_ptr  = w_base;
         w_wptr_nx = w_base + ONE;
         if (in_eop) begin
            w_cptr_nx  = w_base + ONE;
            w_state_nx = S_IDLE;
         end else begin
            w_len_nx   = ONE;
            w_state_nx = S_WRITE;
         end
      end
   end

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_active      <= 1'b0;
         r_wptr        <= '0;
         r_cptr        <= '0;
         r_len         <= '0;
         r_sync1       <= '0;
         r_sync2       <= '0;
         r_wr_ptr_gray <= '0;
         r_we          <= 1'b0;
         r_waddr       <= '0;
         r_din         <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_active <= 1'b1;
         r_wptr   <= w_wptr_nx;
         r_cptr   <= w_cptr_nx;
         r_len    <= w_len_nx;
         r_sync1  <= rd_ptr_gray;
         r_sync2  <= r_sync1;
         // Published one cycle after commit so the RAM has already captured the eop word
         r_wr_ptr_gray <= r_cptr ^ (r_cptr >> 1);
         r_we          <= w_wr;
         if (w_wr) begin
            r_waddr <= w_wr_ptr[ADDR_WIDTH-1:0];
            r_din   <= in_data;
         end
         if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      end
   end

   assign we          = r_we;
   assign waddr       = r_waddr;
   assign din         = r_din;
   assign wr_ptr_gray = r_wr_ptr_gray;
   assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_dpram_wr_ctrl.sv
// tb/tb_dpram_wr_ctrl.sv - directed self-checking bench for dpram_wr_ctrl
module tb_dpram_wr_ctrl;

   logic        wr_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_sop = 1'b0;
   logic        in_eop = 1'b0;
   logic [15:0] in_data = '0;
   logic [9:0]  rd_ptr_gray = '0;
   logic        in_ready;
   logic        we;
   logic [8:0]  waddr;
   logic [15:0] din;
   logic [9:0]  wr_ptr_gray;
   logic [15:0] drop_cnt;

   int n_vec  = 0;
   int n_miss = 0;

   dpram_wr_ctrl dut (
      .wr_clk     (wr_clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sop     (in_sop),
      .in_eop     (in_eop),
      .in_data    (in_data),
      .rd_ptr_gray(rd_ptr_gray),
      .we         (we),
      .waddr      (waddr),
      .din        (din),
      .wr_ptr_gray(wr_ptr_gray),
      .drop_cnt   (drop_cnt)
   );

   always #5 wr_clk = ~wr_clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1, "watchdog");
   end

   function automatic logic [9:0] gray(input logic [9:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic tick();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid    = 1'b0;
      in_sop      = 1'b0;
      in_eop      = 1'b0;
      rd_ptr_gray = '0;
      rst_n       = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Presents one beat, waits (bounded) for in_ready, returns one cycle after acceptance.
   task automatic send(input logic sop, input logic eop, input logic [15:0] d);
      int wait_n = 0;
      in_valid = 1'b1;
      in_sop   = sop;
      in_eop   = eop;
      in_data  = d;
      while (!in_ready && wait_n < 20) begin
         tick();
         wait_n++;
      end
      if (!in_ready) begin
         $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
         n_miss++;
         n_vec++;
      end else begin
         tick();
      end
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      if ({in_ready, we, waddr, din, wr_ptr_gray, drop_cnt} !== '0) begin
         $display("FAIL reset_outputs ready=%0b we=%0b waddr=%0h din=%0h gray=%0h drop=%0d required all 0",
                  in_ready, we, waddr, din, wr_ptr_gray, drop_cnt);
         n_miss++;
      end
      n_vec++;
      do_reset();
      if (in_ready !== 1'b1) begin
         $display("FAIL reset_release_ready got=%0b required 1", in_ready);
         n_miss++;
      end
      n_vec++;
      send(1'b1, 1'b0, 16'hA5A5);
      send(1'b0, 1'b0, 16'h5A5A);
      if (we !== 1'b1 || waddr !== 9'd1 || din !== 16'h5A5A) begin
         $display("FAIL reset_prepacket we=%0b waddr=%0h din=%0h required 1/1/5a5a", we, waddr, din);
         n_miss++;
      end
      n_vec++;
      rst_n = 1'b0;
      #1;
      if ({in_ready, we, waddr, din, wr_ptr_gray, drop_cnt} !== '0) begin
         $display("FAIL reset_midpacket ready=%0b we=%0b waddr=%0h din=%0h gray=%0h drop=%0d required all 0",
                  in_ready, we, waddr, din, wr_ptr_gray, drop_cnt);
         n_miss++;
      end
      n_vec++;
      tick();
      rst_n = 1'b1;
      tick();
      if (in_ready !== 1'b1) begin
         $display("FAIL reset_rerelease_ready got=%0b required 1", in_ready);
         n_miss++;
      end
      n_vec++;
   endtask

   task automatic test_single_packet();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(i == 0, i == 3, 16'(i + 1));
         if (we !== 1'b1 || waddr !== 9'(i) || din !== 16'(i + 1)) begin
            $display("FAIL single_write%0d we=%0b waddr=%0h din=%0h required 1/%0h/%0h",
                     i, we, waddr, din, i, i + 1);
            n_miss++;
         end
         n_vec++;
         if (wr_ptr_gray !== 10'h000) begin
            $display("FAIL single_early_commit%0d gray=%0h required 0", i, wr_ptr_gray);
            n_miss++;
         end
         n_vec++;
      end
      tick();
      if (wr_ptr_gray !== 10'h006 || we !== 1'b0) begin
         $display("FAIL single_commit gray=%0h we=%0b required 006/0", wr_ptr_gray, we);
         n_miss++;
      end
      n_vec++;
   endtask

   task automatic test_protocol_errors();
      do_reset();
      send(1'b0, 1'b0, 16'h1111);
      if (we !== 1'b0 || drop_cnt !== 16'd0) begin
         $display("FAIL nosop_idle we=%0b drop=%0d required 0/0", we, drop_cnt);
         n_miss++;
      end
      n_vec++;
      for (int i = 0; i < 3; i++) begin
         send(i == 0, 1'b0, 16'hA000 + 16'(i));
         if (we !== 1'b1 || waddr !== 9'(i)) begin
            $display("FAIL proto_a%0d we=%0b waddr=%0h required 1/%0h", i, we, waddr, i);
            n_miss++;
         end
         n_vec++;
      end
      send(1'b1, 1'b0, 16'hB000);
      if (drop_cnt !== 16'd1 || we !== 1'b1 || waddr !== 9'd0 || din !== 16'hB000) begin
         $display("FAIL sop_in_write drop=%0d we=%0b waddr=%0h din=%0h required 1/1/0/b000",
                  drop_cnt, we, waddr, din);
         n_miss++;
      end
      n_vec++;
      send(1'b0, 1'b1, 16'hB001);
      if (we !== 1'b1 || waddr !== 9'd1) begin
         $display("FAIL proto_b1 we=%0b waddr=%0h required 1/1", we, waddr);
         n_miss++;
      end
      n_vec++;
      tick();
      if (wr_ptr_gray !== 10'h003) begin
         $display("FAIL proto_commit gray=%0h required 003", wr_ptr_gray);
         n_miss++;
      end
      n_vec++;
   endtask

   task automatic test_wrap_around();
      int wp = 0;
      logic [8:0] prev = '0;
      logic saw_wrap = 1'b0;
      do_reset();
      for (int p = 0; p < 110; p++) begin
         for (int w = 0; w < 10; w++) begin
            send(w == 0, w == 9, 16'(p * 10 + w));
            if (we !== 1'b1 || waddr !== 9'(wp % 512)) begin
               $display("FAIL wrap_waddr p%0d w%0d we=%0b waddr=%0h required 1/%0h",
                        p, w, we, waddr, wp % 512);
               n_miss++;
            end
            n_vec++;
            if (prev == 9'd511 && waddr == 9'd0) saw_wrap = 1'b1;
            prev = waddr;
            wp++;
         end
         tick();
         if (wr_ptr_gray !== gray(10'(wp % 1024))) begin
            $display("FAIL wrap_gray p%0d gray=%0h required %0h", p, wr_ptr_gray, gray(10'(wp % 1024)));
            n_miss++;
         end
         n_vec++;
         rd_ptr_gray = gray(10'(wp % 1024));
      end
      if (saw_wrap !== 1'b1) begin
         $display("FAIL wrap_511_to_0 seen=%0b required 1", saw_wrap);
         n_miss++;
      end
      n_vec++;
   endtask

   task automatic test_fill();
      int n = 0;
      do_reset();
      for (int p = 0; p < 64; p++)
         for (int w = 0; w < 8; w++)
            send(w == 0, w == 7, 16'(p * 8 + w));
`ifdef DPRAM_WR_DROP_ON_FULL_EN
      if (in_ready !== 1'b1) begin
         $display("FAIL fill_ready got=%0b required 1", in_ready);
         n_miss++;
      end
`else
      if (in_ready !== 1'b0) begin
         $display("FAIL fill_ready got=%0b required 0", in_ready);
         n_miss++;
      end
`endif
      n_vec++;
      tick();
      if (wr_ptr_gray !== 10'h300 || drop_cnt !== 16'd0) begin
         $display("FAIL fill_commit gray=%0h drop=%0d required 300/0", wr_ptr_gray, drop_cnt);
         n_miss++;
      end
      n_vec++;
`ifdef DPRAM_WR_DROP_ON_FULL_EN
      for (int w = 0; w < 8; w++) begin
         send(w == 0, w == 7, 16'hD000 + 16'(w));
         if (we !== 1'b0) begin
            $display("FAIL fill_drop_write w%0d we=%0b required 0", w, we);
            n_miss++;
         end
         n_vec++;
      end
      tick();
      tick();
      if (drop_cnt !== 16'd1 || wr_ptr_gray !== 10'h300) begin
         $display("FAIL fill_drop drop=%0d gray=%0h required 1/300", drop_cnt, wr_ptr_gray);
         n_miss++;
      end
      n_vec++;
`else
      rd_ptr_gray = 10'h00C;
      while (!in_ready && n < 3) begin
         tick();
         n++;
      end
      if (in_ready !== 1'b1) begin
         $display("FAIL fill_ready_return got=%0b required 1", in_ready);
         n_miss++;
      end
      n_vec++;
      send(1'b1, 1'b0, 16'hC000);
      if (we !== 1'b1 || waddr !== 9'd0 || din !== 16'hC000) begin
         $display("FAIL fill_resume we=%0b waddr=%0h din=%0h required 1/0/c000", we, waddr, din);
         n_miss++;
      end
      n_vec++;
`endif
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_protocol_errors();
      test_wrap_around();
      test_fill();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/dpram_wr_ctrl.md
# dpram_wr_ctrl

Write-side packet controller for the dual-clock `dpram_aclk` buffer in the switch datapath. It accepts a valid/ready word stream with start- and end-of-packet markers in the `wr_clk` domain and drives the RAM's write port (`we`/`waddr`/`din`). It publishes a Gray-coded committed write pointer to the read clock domain. Only complete packets become visible to the reader; partial or overflowing packets are rolled back.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 9: RAM address width; depth `2^ADDR_WIDTH` words.
- `DATA_WIDTH`, default 16: word width.
- `CNT_WIDTH`, default 16: width of `drop_cnt`.

**Ports**
- `wr_clk`  in  1  write clock; all logic in this domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `in_sop`  in  1  first word of packet.
- `in_eop`  in  1  last word of packet; may coincide with `in_sop`.
- `in_data`  in  DATA_WIDTH  payload word.
- `rd_ptr_gray`  in  ADDR_WIDTH+1  reader's Gray pointer, `rd_clk` domain.
- `we`  out  1  RAM write enable.
- `waddr`  out  ADDR_WIDTH  RAM write address.
- `din`  out  DATA_WIDTH  RAM write data.
- `wr_ptr_gray`  out  ADDR_WIDTH+1  committed write pointer, Gray-coded, registered.
- `drop_cnt`  out  CNT_WIDTH  packets dropped; saturates at all-ones.

## Operation

**Pointers**
- `wptr` is the working pointer and `cptr` the committed pointer; both are binary, ADDR_WIDTH+1 bits, and wrap modulo `2^(ADDR_WIDTH+1)`.
- `rd_ptr_gray` passes through a 2-flop synchronizer (reset 0) and is then Gray-decoded to give `rptr`.
- `free = 2^ADDR_WIDTH - (wptr - rptr)`; full when `free == 0`.

**Accepted beats**
- Each accepted beat is written at `waddr = wptr[ADDR_WIDTH-1:0]`, then `wptr` increments.

**State machine**
- **IDLE**
  - Accepted `sop` with room: write the word. If `eop` is also set, commit; otherwise go to WRITE.
  - Accepted beat without `sop`: discard silently. `drop_cnt` is unchanged.
- **WRITE**
  - Accepted beat: write the word.
  - `eop`: commit (`cptr <= wptr + 1`) and go to IDLE.
  - `sop` arriving in WRITE: abandon the current packet (`wptr <= cptr`), increment `drop_cnt`, and start the new packet with this word.
  - Packet length reaches `2^ADDR_WIDTH` words without `eop`: set `wptr <= cptr`, increment `drop_cnt`, go to DROP.
- **DROP**
  - Consume beats without writing. On `eop`, go to IDLE.

**Publishing**
- `wr_ptr_gray` is `cptr` converted to Gray code (`b ^ (b>>1)`). It updates only on commit, so it changes by exactly one packet at a time.

## Timing

**Reset values**
- Asynchronous on `rst_n` low: `in_ready=0`, `we=0`, `waddr=0`, `din=0`, `wr_ptr_gray=0`, `drop_cnt=0`, state IDLE, `wptr=cptr=0`, synchronizer flops 0.
- `in_ready` may rise from the first `wr_clk` edge after release.

**Write-port latency**
- A beat accepted in cycle N drives `we=1`, `waddr` and `din` in cycle N+1. All three are registered.

**Commit latency**
- For an `eop` beat accepted in cycle N, `wr_ptr_gray` changes in cycle N+2, after the RAM has captured the word.

**Reader-side visibility**
- A change on `rd_ptr_gray` affects `free`/`in_ready` no later than 3 `wr_clk` edges later.

**Rollback**
- Rollback and drop take effect in the same cycle as the triggering beat. `wr_ptr_gray` is never affected by them.

**Reset mid-packet**
- All uncommitted and committed state is lost. The read side must be reset together with this block.

## Configuration

The macro `DPRAM_WR_DROP_ON_FULL_EN` selects full behaviour.

**Defined**
- `in_ready = 1` whenever out of reset.
- Beat arriving with `free == 0`:
  - In IDLE: the packet is dropped; go to DROP, or stay in IDLE if `sop & eop`.
  - In WRITE: roll back to `cptr` and go to DROP.
- Both cases increment `drop_cnt`.

**Undefined (backpressure)**
- `in_ready = (free != 0)` in IDLE and WRITE; `in_ready = 1` in DROP.
- Only oversize packets and `sop`-in-WRITE increment `drop_cnt`.

## Test plan

- **Reset:** assert `rst_n=0` mid-packet. Required: all outputs 0 immediately; after release with `rd_ptr_gray=0`, `in_ready=1`.
- **Single packet:** 4-word packet `0x0001..0x0004`. Required: `we` pulses at `waddr` 0..3 with matching `din`; `wr_ptr_gray` stays 0 until cycle N+2 after the `eop` beat, then equals `0x006`.
- **Fill without macro:** `rd_ptr_gray` held at 0; stream 8-word packets. Required: after 64 packets `in_ready=0`. Then set `rd_ptr_gray=0x00C`. Required: `in_ready` returns within 3 cycles and the next word is written at `waddr=0`.
- **Fill with macro:** same stimulus as above. Required: the 65th packet performs no RAM writes, `drop_cnt=1`, `wr_ptr_gray` stays `gray(512)=0x300`.
- **Wrap-around:** reader tracks writer; stream 1100 words. Required: `waddr` wraps 511→0; `wr_ptr_gray` follows `gray(cptr)` across 1023→0.
- **Protocol errors:**
  - `sop` arriving at word 3 of a packet. Required: `drop_cnt` increments and the new packet reuses the same start address.
  - Non-`sop` beat in IDLE. Required: no `we`, `drop_cnt` unchanged.
